lights_out_ctrl: RTL

Game controller for the 3x3 lights-out puzzle. Detects button presses, applies the toggle pattern of the pressed cell and its orthogonal neighbours to the 9-cell field register, and counts moves. Generates a guaranteed-solvable random puzzle on request and flags the solved condition. Sits between the top-level pad mapping (ui_in[7:0] and uio_in[0] as buttons; uo_out[7:0] and uio_out[0] as lamps) and the field display.

---
 rtl/lights_out_pkg.sv | 38 +++
 rtl/lights_out_lfsr.sv | 36 +++
 rtl/lights_out_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lights_out_pkg.sv
// Shared types and constants for the 3x3 lights-out controller.
// Toggle masks, state encoding and the lowest-set-bit helper.
package lights_out_pkg;

    localparam int N_CELLS = 9;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        SCRAMBLE = 2'd1,
        WON      = 2'd2
    } state_e;

    // Cell i toggles itself and its orthogonal neighbours (row-major).
    localparam logic [8:0] TOGGLE_MASK [N_CELLS] = '{
        9'h00B, 9'h017, 9'h026,
        9'h059, 9'h0BA, 9'h134,
        9'h0C8, 9'h1D0, 9'h1A0
    };

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } lowest_t;

    // Index of the lowest set bit; valid=0 when no bit is set.
    function automatic lowest_t lowest_one(input logic [8:0] v);
        lowest_t r;
        r = '0;
        for (int i = N_CELLS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lights_out_lfsr.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, left-shifting.
// Advances once per enabled cycle; output is the current state.
module lights_out_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        fb;

    // Next state: shift in the tap parity when enabled.
    always_comb begin
        fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d = lfsr_q;
        if (ena) begin
            lfsr_d = {lfsr_q[14:0], fb};
        end
    end

    // State register, reloads SEED on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/lights_out_ctrl.sv
// Lights-out game controller: press detection, field toggling,
// move counting, solvable scrambling and solved/busy flags.
module lights_out_ctrl
    import lights_out_pkg::*;
#(
    parameter logic [15:0] SEED             = 16'hACE1,
    parameter int unsigned SCRAMBLE_PRESSES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [8:0] btn,
    input  logic       new_game,
    output logic [8:0] field,
    output logic       solved,
    output logic       busy,
    output logic [7:0] move_count
);

    localparam logic [7:0] SCR_N = 8'(SCRAMBLE_PRESSES);

    state_e      state_q, state_d;
    logic [8:0]  field_q, field_d;
    logic [7:0]  move_q, move_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  prev_q, prev_d;
    logic        solved_q, solved_d;
    logic        busy_q, busy_d;

    logic [15:0] lfsr;
    logic [3:0]  k;
    logic [11:0] unused_lfsr_hi;
    logic [8:0]  rise;
    lowest_t     low;

    lights_out_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .lfsr (lfsr)
    );

    assign k              = lfsr[3:0];
    assign unused_lfsr_hi = lfsr[15:4];
    assign rise           = btn & ~prev_q;
    assign low            = lowest_one(rise);

    // Next-state logic: new_game beats presses; ena=0 holds everything.
    always_comb begin
        state_d = state_q;
        field_d = field_q;
        move_d  = move_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        if (ena) begin
            prev_d = btn;
            if (new_game) begin
                state_d = SCRAMBLE;
                field_d = '0;
                move_d  = '0;
                cnt_d   = '0;
            end else begin
                unique case (state_q)
                    PLAY: begin
                        if (low.valid) begin
                            field_d = field_q ^ TOGGLE_MASK[low.idx];
                            if (move_q != 8'hFF) begin
                                move_d = move_q + 8'd1;
                            end
                            if (field_d == '0) begin
                                state_d = WON;
                            end
                        end
                    end
                    SCRAMBLE: begin
                        if (k < 4'(N_CELLS)) begin
                            field_d = field_q ^ TOGGLE_MASK[k];
                            cnt_d   = cnt_q + 8'd1;
                            if (cnt_d == SCR_N) begin
                                cnt_d = '0;
                                if (field_d != '0) begin
                                    state_d = PLAY;
                                end
                            end
                        end
                    end
                    WON: begin
                        state_d = WON;
                    end
                    default: begin
                        state_d = PLAY;
                    end
                endcase
            end
        end
        solved_d = (state_d == WON);
        busy_d   = (state_d == SCRAMBLE);
    end

    // Game FSM and its registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PLAY;
            field_q  <= 9'h010;
            move_q   <= '0;
            cnt_q    <= '0;
            prev_q   <= 9'h1FF;
            solved_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            field_q  <= field_d;
            move_q   <= move_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            solved_q <= solved_d;
            busy_q   <= busy_d;
        end
    end

    assign field      = field_q;
    assign solved     = solved_q;
    assign busy       = busy_q;
    assign move_count = move_q;

endmodule
